spi_master_arb: RTL and testbench
=================================

Name: spi_master_arb

Overview:
- Mode-0 SPI master that drives the team's spi_slave (sclk/cs/mosi/miso) and shares one SPI link between two requesters.
- Round-robin arbitration picks one requester per transfer, shifts DATA_W bits MSB-first and returns the received word with a done pulse to the owner.
- Sits between on-chip clients and the spi_slave pins, so CS, SCLK and bit-timing sequencing live in one place.

Parameters:
- DATA_W, 8, bits per transfer (>=2)
- CLK_DIV, 2, clk cycles per sclk half-period (>=1)
- CS_SETUP, 2, clk cycles from cs falling to first sclk rising-phase start (>=1)
- CS_HOLD, 2, clk cycles from last sclk falling edge to cs rising (>=1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req0  in  1  requester 0 transfer request, level, hold until gnt0
- wdata0  in  DATA_W  requester 0 transmit word, sampled at grant
- gnt0  out  1  1-cycle pulse: request 0 accepted
- done0  out  1  1-cycle pulse: requester 0 transfer complete, rdata valid
- req1, wdata1, gnt1, done1: as above for requester 1
- rdata  out  DATA_W  last received word, held until next done
- busy  out  1  high from grant cycle through end of HOLD
- sclk  out  1  SPI clock, idle low
- cs  out  1  SPI chip select, active low
- mosi  out  1  master-out data
- miso  in  1  master-in data

Behaviour:
- Reset (rst=0, async): sclk=0, cs=1, mosi=0, gnt0/1=0, done0/1=0, busy=0, rdata=0, state=IDLE, last-served pointer=1 (so requester 0 wins the first tie). Outputs take these values immediately on assertion. Reset mid-transfer aborts it: no done pulse, and the word is lost.
- States: IDLE -> SETUP -> SHIFT_LO <-> SHIFT_HI -> HOLD -> IDLE.
- IDLE:
  - req sampled only here. One req high wins; both high selects the one not last served.
  - At the grant edge: gnt pulse for the winner, owner and pointer updated, shift reg <= wdata, cs<=0, mosi<=wdata[DATA_W-1], busy<=1, state SETUP.
- SETUP: CS_SETUP cycles with sclk=0, then SHIFT_LO.
- SHIFT_LO:
  - CLK_DIV cycles with sclk=0.
  - On its last cycle edge: sclk<=1, miso sampled into shift reg LSB, bit count+1, state SHIFT_HI.
- SHIFT_HI:
  - CLK_DIV cycles with sclk=1, then sclk<=0.
  - If bit count<DATA_W: mosi<=next bit (MSB-first), state SHIFT_LO.
  - Otherwise: mosi<=0, state HOLD.
- HOLD:
  - CS_HOLD cycles with sclk=0, cs=0.
  - Then cs<=1, rdata<=shift reg, done pulse to owner, busy<=0, state IDLE.
- cs stays high at least 1 cycle between transfers, since a grant is only possible from IDLE.
- cs low duration = CS_SETUP + 2*CLK_DIV*DATA_W + CS_HOLD cycles. Exactly DATA_W rising sclk edges per transfer.
- mosi is stable across every rising sclk edge: it changes only at cs fall or sclk fall.
- req dropped before grant is not served. req still high at return to IDLE re-enters arbitration, so a persistent requester alternates with the other.
- wdata changes after grant have no effect. miso is ignored outside rising-edge sampling.
- gnt and done never assert for both requesters in the same cycle.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req0=1 -> sclk=0, cs=1, mosi=0, busy=0, gnt0=0. Assert rst=0 mid-cycle -> outputs change without waiting for clk.
- Single transfer, defaults: req0=1, wdata0=8'hA5, slave model returns 8'h3C -> 1 gnt0 pulse; mosi at the 8 rising edges = 1,0,1,0,0,1,0,1; cs low exactly 36 cycles; rdata=8'h3C; one done0 pulse, no done1.
- Tie after reset: req0=req1=1, wdata0=8'h5A, wdata1=8'hC3 -> requester 0 first, then requester 1; mosi words 5A then C3; cs high >=1 cycle between transfers.
- Fairness: req0 and req1 held high for 4 transfers -> grant order 0,1,0,1; each done matches its own gnt.
- Reset mid-transfer after 4th rising sclk edge -> cs=1 and sclk=0 immediately, no done. After release, req1 alone -> served normally with correct data.
- CLK_DIV=1, DATA_W=8 -> sclk period 2 clk cycles; cs low 20 cycles; loopback miso=mosi returns rdata=wdata.

Source files
------------

// File: rtl/spi_master_arb.sv
// Mode-0 SPI master shared by two requesters through a round-robin arbiter.
// One requester owns the link per transfer. The transfer shifts DATA_W bits MSB-first,
// then returns the received word with a done pulse to the owner.
module spi_master_arb #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              done0,
   input  logic              req1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              sclk,
   output logic              cs,
   output logic              mosi,
   input  logic              miso
);

   // Phase counter must hold the longest of the setup, half-period and hold intervals.
   localparam int unsigned CNT_MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > CS_HOLD) ? CNT_MAX_A : CS_HOLD;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam int unsigned BIT_W     = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      HOLD     = 3'd4
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              owner;     // 1 when requester 1 owns the current transfer
   logic              last;      // requester served most recently
   logic              pick1_c;
   logic [DATA_W-1:0] wsel_c;

   // Round-robin pick: a lone request wins, and a tie goes to the requester not served last.
   assign pick1_c = req1 && (!req0 || !last);
   assign wsel_c  = pick1_c ? wdata1 : wdata0;

   // Transfer sequencer: arbitration, CS framing, SCLK generation and shifting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         owner   <= 1'b0;
         last    <= 1'b1;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         rdata   <= '0;
         busy    <= 1'b0;
         sclk    <= 1'b0;
         cs      <= 1'b1;
         mosi    <= 1'b0;
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner   <= pick1_c;
                  last    <= pick1_c;
                  gnt0    <= !pick1_c;
                  gnt1    <= pick1_c;
                  shreg   <= wsel_c;
                  mosi    <= wsel_c[DATA_W-1];
                  cs      <= 1'b0;
                  busy    <= 1'b1;
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == CNT_W'(CS_SETUP - 1)) begin
                  cnt   <= '0;
                  state <= SHIFT_LO;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SHIFT_LO: begin
               if (cnt == CNT_W'(CLK_DIV - 1)) begin
                  cnt     <= '0;
                  sclk    <= 1'b1;
                  shreg   <= {shreg[DATA_W-2:0], miso};
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  state   <= SHIFT_HI;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SHIFT_HI: begin
               if (cnt == CNT_W'(CLK_DIV - 1)) begin
                  cnt  <= '0;
                  sclk <= 1'b0;
                  if (bit_cnt < BIT_W'(DATA_W)) begin
                     // After the shift, the next transmit bit sits at the MSB.
                     mosi  <= shreg[DATA_W-1];
                     state <= SHIFT_LO;
                  end else begin
                     mosi  <= 1'b0;
                     state <= HOLD;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HOLD: begin
               if (cnt == CNT_W'(CS_HOLD - 1)) begin
                  cnt   <= '0;
                  cs    <= 1'b1;
                  rdata <= shreg;
                  done0 <= !owner;
                  done1 <= owner;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_arb.sv
// Testbench for spi_master_arb: a randomized round-robin reference model plus an SPI slave model.
module tb_spi_master_arb;

   localparam int DW     = 8;
   localparam int CS_LO  = 2 + 2 * 2 * DW + 2;   // setup + shift + hold, default instance
   localparam int F_CSLO = 2 + 2 * 1 * DW + 2;   // CLK_DIV = 1 instance

   logic          clk;
   logic          rst;
   logic          req0, req1, gnt0, gnt1, done0, done1;
   logic [DW-1:0] wdata0, wdata1, rdata;
   logic          busy, sclk, cs, mosi, miso;

   logic          f_rst;
   logic          f_req0, f_req1, f_gnt0, f_gnt1, f_done0, f_done1;
   logic [DW-1:0] f_wdata0, f_wdata1, f_rdata;
   logic          f_busy, f_sclk, f_cs, f_mosi;

   int n_tests;
   int n_fail;
   bit m_last;                 // reference model: requester served most recently

   // Slave model state
   logic [DW-1:0] next_tx, s_tx, s_rx;
   int            s_bit;

   spi_master_arb #(.DATA_W(DW), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
      .req1(req1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
      .rdata(rdata), .busy(busy), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
   );

   spi_master_arb #(.DATA_W(DW), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) fdut (
      .clk(clk), .rst(f_rst),
      .req0(f_req0), .wdata0(f_wdata0), .gnt0(f_gnt0), .done0(f_done0),
      .req1(f_req1), .wdata1(f_wdata1), .gnt1(f_gnt1), .done1(f_done1),
      .rdata(f_rdata), .busy(f_busy), .sclk(f_sclk), .cs(f_cs), .mosi(f_mosi), .miso(f_mosi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mode-0 slave: loads a word at cs fall, samples mosi on sclk rise, and drives miso after sclk fall.
   always @(negedge cs) begin
      s_tx  = next_tx;
      s_rx  = '0;
      s_bit = 0;
      miso  = s_tx[DW-1];
   end
   always @(posedge sclk) begin
      s_rx  = {s_rx[DW-2:0], mosi};
      s_bit = s_bit + 1;
   end
   always @(negedge sclk) begin
      if (!cs && s_bit < DW) miso = s_tx[DW-1-s_bit];
   end
   always @(posedge cs) miso = 1'($urandom);

   task automatic do_reset();
      rst = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      m_last = 1'b1;
      @(negedge clk);
   endtask

   // Runs n transfers with the given request levels held and checks each against the model.
   task automatic run_xfer(input bit r0, input bit r1, input int n, input bit rand_rx);
      bit            found, exp_own;
      logic [DW-1:0] exp_word, exp_rx;
      int            lo, extra;
      req0 = r0; req1 = r1;
      for (int k = 0; k < n; k++) begin
         if (rand_rx || k > 0) next_tx = DW'($urandom);
         found = 1'b0;
         for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin found = 1'b1; break; end
         end
         n_tests++;
         if (!found) begin
            $display("FAIL grant_timeout: got no grant, required one within 100 cycles");
            n_fail++;
            req0 = 1'b0; req1 = 1'b0;
            return;
         end
         exp_own  = (r0 && r1) ? !m_last : r1;
         m_last   = exp_own;
         exp_word = exp_own ? wdata1 : wdata0;
         exp_rx   = next_tx;
         n_tests++;
         if ((gnt0 && gnt1) || gnt1 !== exp_own) begin
            $display("FAIL grant_owner: got gnt0=%b gnt1=%b, required owner %0d", gnt0, gnt1, exp_own);
            n_fail++;
         end
         // wdata of the granted requester changes right after the grant; the word already taken must not change.
         if (exp_own) wdata1 = DW'($urandom); else wdata0 = DW'($urandom);
         lo = 1; extra = 0;
         for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (cs !== 1'b0) break;
            lo++;
            if (gnt0 || gnt1 || done0 || done1 || busy !== 1'b1) extra++;
         end
         if (k == n - 1) begin req0 = 1'b0; req1 = 1'b0; end
         n_tests++;
         if (lo != CS_LO) begin
            $display("FAIL cs_low_len: got %0d cycles, required %0d", lo, CS_LO); n_fail++;
         end
         n_tests++;
         if (extra != 0) begin
            $display("FAIL stray_pulse: got %0d bad cycles, required 0", extra); n_fail++;
         end
         n_tests++;
         if (s_bit != DW) begin
            $display("FAIL sclk_edges: got %0d, required %0d", s_bit, DW); n_fail++;
         end
         n_tests++;
         if (s_rx !== exp_word) begin
            $display("FAIL mosi_word: got %h, required %h", s_rx, exp_word); n_fail++;
         end
         n_tests++;
         if (rdata !== exp_rx) begin
            $display("FAIL rdata: got %h, required %h", rdata, exp_rx); n_fail++;
         end
         n_tests++;
         if (exp_own ? !(done1 === 1'b1 && done0 === 1'b0) : !(done0 === 1'b1 && done1 === 1'b0)) begin
            $display("FAIL done_owner: got done0=%b done1=%b, required owner %0d", done0, done1, exp_own);
            n_fail++;
         end
         n_tests++;
         if (cs !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL idle_gap: got cs=%b busy=%b, required cs=1 busy=0", cs, busy); n_fail++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req0 = 1'b1; req1 = 1'b0;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({sclk, cs, mosi, busy, gnt0, gnt1, done0, done1} !== 8'b0100_0000 || rdata !== '0) begin
         $display("FAIL reset_values: got sclk=%b cs=%b mosi=%b busy=%b gnt0=%b rdata=%h, required 0 1 0 0 0 00",
                  sclk, cs, mosi, busy, gnt0, rdata);
         n_fail++;
      end
      rst = 1'b1;
      wdata0 = 8'hFF;
      repeat (3) @(negedge clk);
      req0 = 1'b0;
      n_tests++;
      if (cs !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL reset_start: got cs=%b busy=%b, required 0 1", cs, busy); n_fail++;
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (cs !== 1'b1 || busy !== 1'b0 || mosi !== 1'b0) begin
         $display("FAIL reset_async: got cs=%b busy=%b mosi=%b, required 1 0 0", cs, busy, mosi); n_fail++;
      end
      @(negedge clk);
      rst = 1'b1;
      m_last = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      wdata0  = 8'hA5;
      next_tx = 8'h3C;
      run_xfer(1'b1, 1'b0, 1, 1'b0);
   endtask

   task automatic test_tie();
      do_reset();
      wdata0 = 8'h5A; wdata1 = 8'hC3;
      run_xfer(1'b1, 1'b1, 2, 1'b1);
   endtask

   task automatic test_fairness();
      wdata0 = DW'($urandom); wdata1 = DW'($urandom);
      run_xfer(1'b1, 1'b1, 4, 1'b1);
   endtask

   task automatic test_random();
      bit r0, r1;
      for (int i = 0; i < 6; i++) begin
         r0 = 1'($urandom); r1 = 1'($urandom);
         if (!r0 && !r1) r0 = 1'b1;
         wdata0 = DW'($urandom); wdata1 = DW'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_xfer(r0, r1, int'($urandom_range(1, 3)), 1'b1);
      end
   endtask

   // A request raised and dropped while the link is busy is never served.
   task automatic test_drop();
      int g1;
      g1 = 0;
      next_tx = DW'($urandom);
      wdata0 = DW'($urandom);
      req0 = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (gnt0) req0 = 1'b0;
         if (t == 5) req1 = 1'b1;
         if (t == 20) req1 = 1'b0;
         if (gnt1) g1++;
      end
      n_tests++;
      if (g1 != 0 || busy !== 1'b0) begin
         $display("FAIL dropped_req: got gnt1 count %0d busy=%b, required 0 0", g1, busy); n_fail++;
      end
   endtask

   task automatic test_abort();
      int dn;
      bit found;
      wdata0 = DW'($urandom);
      next_tx = DW'($urandom);
      req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (!cs && s_bit == 4 && sclk) begin found = 1'b1; break; end
      end
      n_tests++;
      if (!found) begin
         $display("FAIL abort_wait: got no 4th sclk edge, required one"); n_fail++;
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (cs !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL abort_async: got cs=%b sclk=%b busy=%b, required 1 0 0", cs, sclk, busy); n_fail++;
      end
      dn = 0;
      repeat (2) begin @(negedge clk); if (done0 || done1) dn++; end
      rst = 1'b1;
      m_last = 1'b1;
      repeat (5) begin @(negedge clk); if (done0 || done1 || busy) dn++; end
      n_tests++;
      if (dn != 0) begin
         $display("FAIL abort_no_done: got %0d done/busy cycles, required 0", dn); n_fail++;
      end
      wdata1 = DW'($urandom);
      run_xfer(1'b0, 1'b1, 1, 1'b1);
   endtask

   // Faster sclk with miso looped back from mosi.
   task automatic test_fast();
      logic [DW-1:0] w;
      int lo, rises, bad;
      bit found, ps;
      for (int i = 0; i < 3; i++) begin
         w = DW'($urandom);
         f_wdata0 = w;
         f_req0 = 1'b1;
         found = 1'b0;
         for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (f_gnt0) begin found = 1'b1; break; end
         end
         f_req0 = 1'b0;
         f_wdata0 = ~w;
         lo = 1; rises = 0; bad = 0; ps = f_sclk;
         for (int t = 0; t < 100 && found; t++) begin
            @(negedge clk);
            if (f_cs !== 1'b0) break;
            lo++;
            if (f_sclk && !ps) rises++;
            if (f_sclk && ps) bad++;
            ps = f_sclk;
         end
         n_tests++;
         if (!found || lo != F_CSLO || rises != DW || bad != 0) begin
            $display("FAIL fast_timing: got found=%b cs_low=%0d rises=%0d wide_hi=%0d, required 1 %0d %0d 0",
                     found, lo, rises, bad, F_CSLO, DW);
            n_fail++;
         end
         n_tests++;
         if (f_rdata !== w || f_done0 !== 1'b1) begin
            $display("FAIL fast_loopback: got rdata=%h done0=%b, required %h 1", f_rdata, f_done0, w); n_fail++;
         end
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      m_last = 1'b1;
      miso = 1'b0; next_tx = '0; s_bit = 0; s_rx = '0; s_tx = '0;
      req0 = 1'b0; req1 = 1'b0; wdata0 = '0; wdata1 = '0;
      f_rst = 1'b0; f_req0 = 1'b0; f_req1 = 1'b0; f_wdata0 = '0; f_wdata1 = '0;
      test_reset();
      f_rst = 1'b1;
      test_single();
      test_tie();
      test_fairness();
      test_random();
      test_drop();
      test_abort();
      test_fast();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
